// File: rtl/mqam_modulator.sv
// Runtime-selectable BPSK / QPSK / 16-QAM modulator.
// A symbol-rate FSM pulls symbols over a valid/ready handshake and maps them
// to I/Q levels. A phase-accumulator DDS supplies the sin/cos carrier. The
// mixed, saturated sample drives both tx_sample_o and a first-order PDM stage.
module mqam_modulator #(
  parameter int AMP    = 16000,
  parameter int AMP_LO = AMP / 3,
  parameter int CNT_W  = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [31:0]        fcw_i,
  input  logic               enable_i,
  input  logic [1:0]         mode_i,
  input  logic [CNT_W-1:0]   sym_period_i,
  input  logic [3:0]         sym_data_i,
  input  logic               sym_valid_i,
  output logic               sym_ready_o,
  output logic               underflow_o,
  output logic               busy_o,
  output logic signed [15:0] tx_sample_o,
  output logic               pdm_out_o
);

  localparam logic signed [15:0] AMP_P = 16'(AMP);
  localparam logic signed [15:0] AMP_N = 16'(-AMP);
  localparam logic signed [15:0] LO_P  = 16'(AMP_LO);
  localparam logic signed [15:0] LO_N  = 16'(-AMP_LO);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // DDS: 32-bit phase accumulator. A 16-entry cosine table is addressed by the
  // top four phase bits. The sine is the same table offset by a quarter turn.
  // ---------------------------------------------------------------------------
  logic [31:0]        phase_q;
  logic signed [15:0] dds_sin;
  logic signed [15:0] dds_cos;

  function automatic logic signed [15:0] cos_lut(input logic [3:0] k);
    logic signed [15:0] v;
    case (k)
      4'd0:    v = 16'sd32767;
      4'd1:    v = 16'sd30273;
      4'd2:    v = 16'sd23170;
      4'd3:    v = 16'sd12539;
      4'd4:    v = 16'sd0;
      4'd5:    v = -16'sd12539;
      4'd6:    v = -16'sd23170;
      4'd7:    v = -16'sd30273;
      4'd8:    v = -16'sd32767;
      4'd9:    v = -16'sd30273;
      4'd10:   v = -16'sd23170;
      4'd11:   v = -16'sd12539;
      4'd12:   v = 16'sd0;
      4'd13:   v = 16'sd12539;
      4'd14:   v = 16'sd23170;
      default: v = 16'sd30273;
    endcase
    return v;
  endfunction

  // Phase accumulator advances by the frequency control word every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + fcw_i;
    end
  end

  assign dds_cos = cos_lut(phase_q[31:28]);
  assign dds_sin = cos_lut(phase_q[31:28] - 4'd4);

  // ---------------------------------------------------------------------------
  // Constellation mapping
  // ---------------------------------------------------------------------------
  // Gray-coded 4-level axis: 00 -> -A, 01 -> -a, 11 -> +a, 10 -> +A
  function automatic logic signed [15:0] qam_level(input logic [1:0] g);
    logic signed [15:0] v;
    case (g)
      2'b00:   v = AMP_N;
      2'b01:   v = LO_N;
      2'b11:   v = LO_P;
      default: v = AMP_P;
    endcase
    return v;
  endfunction

  // Returns {I, Q}. The reserved mode 11 falls through to QPSK.
  function automatic logic [31:0] map_sym(input logic [1:0] m, input logic [3:0] d);
    logic signed [15:0] i_v;
    logic signed [15:0] q_v;
    case (m)
      2'b00: begin
        i_v = d[0] ? AMP_N : AMP_P;
        q_v = '0;
      end
      2'b10: begin
        i_v = qam_level(d[3:2]);
        q_v = qam_level(d[1:0]);
      end
      default: begin
        i_v = (d[1] ^ d[0]) ? AMP_N : AMP_P;
        q_v = d[1] ? AMP_N : AMP_P;
      end
    endcase
    return {i_v, q_v};
  endfunction

  // ---------------------------------------------------------------------------
  // Symbol-rate control FSM
  // ---------------------------------------------------------------------------
  state_e              state_q;
  logic [1:0]          mode_q;
  logic [CNT_W-1:0]    per_m1_q;
  logic [CNT_W-1:0]    per_m1_d;
  logic [CNT_W-1:0]    cnt_q;
  logic signed [15:0]  i_val_q;
  logic signed [15:0]  q_val_q;
  logic [31:0]         sym_iq_d;
  logic                busy_q;
  logic                underflow_q;
  logic                boundary;

  // Periods of 0 and 1 are clamped to 2 clocks per symbol.
  always_comb begin
    per_m1_d = (sym_period_i < CNT_W'(2)) ? CNT_W'(1) : sym_period_i - CNT_W'(1);
    sym_iq_d = map_sym(mode_q, sym_data_i);
  end

  assign boundary    = (state_q == ST_RUN) && (cnt_q == per_m1_q);
  assign sym_ready_o = boundary && enable_i;

  // IDLE/RUN sequencing, symbol acceptance and underflow reporting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      per_m1_q    <= '0;
      cnt_q       <= '0;
      i_val_q     <= '0;
      q_val_q     <= '0;
      busy_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable_i) begin
            // The counter is preloaded so that the first RUN cycle is a boundary.
            state_q  <= ST_RUN;
            busy_q   <= 1'b1;
            mode_q   <= mode_i;
            per_m1_q <= per_m1_d;
            cnt_q    <= per_m1_d;
          end
        end
        default: begin
          if (boundary) begin
            cnt_q <= '0;
            if (!enable_i) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              i_val_q <= '0;
              q_val_q <= '0;
            end else if (sym_valid_i) begin
              i_val_q <= sym_iq_d[31:16];
              q_val_q <= sym_iq_d[15:0];
            end else begin
              // Nothing to send: silence the carrier for this symbol.
              i_val_q     <= '0;
              q_val_q     <= '0;
              underflow_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Mixer, saturation and PDM
  // ---------------------------------------------------------------------------
  logic signed [31:0] i_mix_q;
  logic signed [31:0] q_mix_q;
  logic signed [32:0] sum_q;
  logic signed [32:0] sum_shr;
  logic signed [15:0] tx_sample_d;
  logic signed [15:0] tx_sample_q;
  logic signed [17:0] acc_q;
  logic signed [17:0] acc_d;
  logic signed [17:0] s_ext;
  logic               pdm_d;
  logic               pdm_q;

  // Saturate to the symmetric range so the PDM accumulator cannot overflow.
  always_comb begin
    sum_shr     = sum_q >>> 15;
    tx_sample_d = sum_shr[15:0];
    if (sum_shr > 33'sd32767) begin
      tx_sample_d = 16'sd32767;
    end else if (sum_shr < -33'sd32767) begin
      tx_sample_d = -16'sd32767;
    end
  end

  // First-order sigma-delta step on the current output sample.
  always_comb begin
    s_ext = {{2{tx_sample_q[15]}}, tx_sample_q};
    if (!acc_q[17]) begin
      pdm_d = 1'b1;
      acc_d = acc_q + s_ext - 18'sd32767;
    end else begin
      pdm_d = 1'b0;
      acc_d = acc_q + s_ext + 18'sd32767;
    end
  end

  // Three-stage datapath: multiply, I-minus-Q, scale/saturate; PDM follows.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      i_mix_q     <= '0;
      q_mix_q     <= '0;
      sum_q       <= '0;
      tx_sample_q <= '0;
      acc_q       <= '0;
      pdm_q       <= 1'b0;
    end else begin
      i_mix_q     <= i_val_q * dds_cos;
      q_mix_q     <= q_val_q * dds_sin;
      sum_q       <= $signed({i_mix_q[31], i_mix_q}) - $signed({q_mix_q[31], q_mix_q});
      tx_sample_q <= tx_sample_d;
      acc_q       <= acc_d;
      pdm_q       <= pdm_d;
    end
  end

  assign busy_o      = busy_q;
  assign underflow_o = underflow_q;
  assign tx_sample_o = tx_sample_q;
  assign pdm_out_o   = pdm_q;

endmodule

// File: tb/tb_mqam_modulator.sv
// Bench for mqam_modulator. A behavioural model predicts every output on
// every cycle. It covers the symbol schedule as "RUN cycle index modulo the
// period", the ideal constellation points, a trig-derived carrier and a
// three-sample product delay line. Directed steps with hand-computed values
// pin the model, and a randomized run follows.
module tb_mqam_modulator;

  localparam int AMP    = 16000;
  localparam int AMP_LO = AMP / 3;
  localparam int CNT_W  = 16;
  localparam real PI    = 3.14159265358979;

  logic               clk;
  logic               rst_n;
  logic [31:0]        fcw;
  logic               enable;
  logic [1:0]         mode;
  logic [CNT_W-1:0]   sym_period;
  logic [3:0]         sym_data;
  logic               sym_valid;
  logic               sym_ready;
  logic               underflow;
  logic               busy;
  logic signed [15:0] tx_sample;
  logic               pdm_out;

  mqam_modulator #(.AMP(AMP), .AMP_LO(AMP_LO), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .fcw_i        (fcw),
    .enable_i     (enable),
    .mode_i       (mode),
    .sym_period_i (sym_period),
    .sym_data_i   (sym_data),
    .sym_valid_i  (sym_valid),
    .sym_ready_o  (sym_ready),
    .underflow_o  (underflow),
    .busy_o       (busy),
    .tx_sample_o  (tx_sample),
    .pdm_out_o    (pdm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int        cos_tab[16];
  int        sin_tab[16];
  int        lvl[4];          // 16-QAM axis levels indexed by Gray bits
  int        qpsk_i[4];
  int        qpsk_q[4];
  bit        m_run;
  int        m_k;             // RUN cycle index since entering RUN
  int        m_period;
  int        m_mode;
  int        m_i, m_q;
  longint    m_acc;
  int        m_tx;
  bit        m_pdm;
  bit        m_uf;
  logic [31:0] m_phase;
  longint    prod_q[$];

  initial begin
    for (int k = 0; k < 16; k++) begin
      cos_tab[k] = int'($cos(PI * k / 8.0) * 32767.0);
      sin_tab[k] = int'($sin(PI * k / 8.0) * 32767.0);
    end
    lvl[0] = -AMP; lvl[1] = -AMP_LO; lvl[2] = AMP; lvl[3] = AMP_LO;
    qpsk_i[0] = AMP;  qpsk_q[0] = AMP;
    qpsk_i[1] = -AMP; qpsk_q[1] = AMP;
    qpsk_i[2] = -AMP; qpsk_q[2] = -AMP;
    qpsk_i[3] = AMP;  qpsk_q[3] = -AMP;
  end

  task automatic model_reset();
    m_run = 0; m_k = 0; m_period = 2; m_mode = 0;
    m_i = 0; m_q = 0; m_acc = 0; m_tx = 0; m_pdm = 0; m_uf = 0;
    m_phase = '0;
    prod_q = {};
    repeat (3) prod_q.push_back(0);
  endtask

  task automatic ideal_point(input int md, input logic [3:0] d, output int ii, output int qq);
    if (md == 0) begin
      ii = d[0] ? -AMP : AMP;
      qq = 0;
    end else if (md == 2) begin
      ii = lvl[d[3:2]];
      qq = lvl[d[1:0]];
    end else begin
      ii = qpsk_i[d[1:0]];
      qq = qpsk_q[d[1:0]];
    end
  endtask

  task automatic model_step();
    longint p;
    longint sh;
    int     idx;
    // PDM works on the sample that was on the output before this edge
    if (m_acc >= 0) begin
      m_pdm = 1; m_acc = m_acc + m_tx - 32767;
    end else begin
      m_pdm = 0; m_acc = m_acc + m_tx + 32767;
    end
    p  = prod_q.pop_front();
    sh = p >>> 15;
    m_tx = (sh > 32767) ? 32767 : (sh < -32767) ? -32767 : int'(sh);
    // symbol schedule
    m_uf = 0;
    if (!m_run) begin
      if (enable) begin
        m_run = 1; m_k = 0; m_mode = int'(mode);
        m_period = (int'(sym_period) < 2) ? 2 : int'(sym_period);
      end
    end else if (m_k % m_period == 0) begin
      if (!enable) begin
        m_run = 0; m_i = 0; m_q = 0;
      end else if (sym_valid) begin
        ideal_point(m_mode, sym_data, m_i, m_q);
        m_k++;
      end else begin
        m_i = 0; m_q = 0; m_uf = 1;
        m_k++;
      end
    end else begin
      m_k++;
    end
    m_phase = m_phase + fcw;
    idx = int'(m_phase[31:28]);
    prod_q.push_back(longint'(m_i) * cos_tab[idx] - longint'(m_q) * sin_tab[idx]);
  endtask

  // Per-cycle compare process
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    check("cyc_sym_ready", sym_ready, (m_run && (m_k % m_period == 0) && enable) ? 1 : 0);
    check("cyc_busy", busy, m_run);
    check("cyc_underflow", underflow, m_uf);
    check("cyc_tx_sample", $signed(tx_sample), m_tx);
    check("cyc_pdm_out", pdm_out, m_pdm);
  end

  // ---------------- directed helpers ----------------
  task automatic check_zero(input string tag);
    check({tag, "_sym_ready"}, sym_ready, 0);
    check({tag, "_underflow"}, underflow, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_tx_sample"}, $signed(tx_sample), 0);
    check({tag, "_pdm_out"}, pdm_out, 0);
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (sym_ready !== 1'b1 && w < 400) begin
      @(negedge clk); w++;
    end
    if (w >= 400) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic count_to_next_ready(output int w);
    w = 0;
    do begin
      @(negedge clk); w++;
    end while (sym_ready !== 1'b1 && w < 400);
  endtask

  task automatic send(input logic [3:0] d, input int want, input string tag);
    @(negedge clk);
    sym_data  = d;
    sym_valid = 1'b1;
    wait_ready(tag);
    repeat (6) @(negedge clk);
    check(tag, $signed(tx_sample), want);
    $display("tx mode=%0d data=%b -> tx_sample=%0d (want %0d)", mode, d, $signed(tx_sample), want);
  endtask

  task automatic start(input logic [1:0] md, input int per);
    @(negedge clk);
    mode       = md;
    sym_period = CNT_W'(per);
    enable     = 1'b1;
    @(negedge clk);
  endtask

  task automatic go_idle(input string tag);
    int w = 0;
    @(negedge clk);
    enable = 1'b0;
    while (busy !== 1'b0 && w < 400) begin
      @(negedge clk); w++;
    end
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int ones;
    bit seen;
    real exp_ones;

    rst_n = 1'b0; fcw = '0; enable = 1'b0; mode = 2'b01;
    sym_period = CNT_W'(100); sym_data = 4'b0000; sym_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");

    // Start QPSK, period 100, valid held
    rst_n = 1'b1; enable = 1'b1; sym_valid = 1'b1;
    @(negedge clk);
    check("first_ready", sym_ready, 1);
    check("first_busy", busy, 1);
    count_to_next_ready(w);
    check("ready_interval_100", w, 100);

    send(4'b0000, 15999, "qpsk_00");
    // PDM duty over a 64-cycle window of a constant sample
    ones = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      ones += pdm_out;
    end
    exp_ones = 64.0 * (15999.0 + 32767.0) / 65534.0;
    n_cmp++;
    if ($itor(ones) < exp_ones - 2.0 || $itor(ones) > exp_ones + 2.0) begin
      n_bad++;
      $display("FAIL pdm_duty: got %0d ones in 64, expected about %0.1f", ones, exp_ones);
    end
    send(4'b0001, -16000, "qpsk_01");
    send(4'b0010, -16000, "qpsk_10");
    send(4'b0011, 15999, "qpsk_11");

    // 16-QAM
    go_idle("to_qam");
    start(2'b10, 20);
    send(4'b1000, 15999, "qam_1000");
    send(4'b0100, -5333, "qam_0100");

    // BPSK with an underflow boundary
    go_idle("to_bpsk");
    start(2'b00, 10);
    send(4'b0001, -16000, "bpsk_1");
    @(negedge clk);
    sym_valid = 1'b0;
    w = 0;
    while (underflow !== 1'b1 && w < 100) begin
      @(negedge clk); w++;
    end
    check("underflow_seen", underflow, 1);
    sym_valid = 1'b1;
    @(negedge clk);
    check("underflow_one_cycle", underflow, 0);
    repeat (3) @(negedge clk);
    check("underflow_silent_tx", $signed(tx_sample), 0);
    send(4'b0000, 15999, "bpsk_0_resume");

    // Enable dropped mid-symbol, period 8
    go_idle("to_drop");
    start(2'b01, 8);
    wait_ready("drop");
    repeat (3) @(negedge clk);
    enable = 1'b0;
    w = 0; seen = 0;
    do begin
      @(negedge clk); w++;
      if (sym_ready === 1'b1) seen = 1;
    end while (busy === 1'b1 && w < 50);
    check("drop_cycles_to_idle", w, 6);
    check("drop_no_ready", seen, 0);

    // Period 1 clamps to 2
    start(2'b01, 1);
    wait_ready("clamp");
    count_to_next_ready(w);
    check("clamp_interval", w, 2);

    // Async reset mid-symbol
    go_idle("to_rst");
    start(2'b01, 20);
    send(4'b0000, 15999, "pre_reset");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", sym_ready, 1);
    check("post_reset_busy", busy, 1);

    // Randomized run with a moving carrier
    fcw = $urandom;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      sym_data   = 4'($urandom);
      sym_valid  = ($urandom_range(9) < 8);
      mode       = 2'($urandom);
      sym_period = CNT_W'($urandom_range(12));
      if ($urandom_range(49) == 0) enable = ~enable;
      if ($urandom_range(199) == 0) fcw = $urandom;
      rst_n = ($urandom_range(1499) == 0) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
